// File: rtl/seg_display_driver.sv
// Eight-digit multiplexed common-anode seven-segment driver with a snapshot register.
// Define DECIMAL_MODE_EN to include the sequential shift-and-add-3 BCD engine; otherwise digits are hex.
module seg_display_driver #(
  parameter int DATA_BITS = 32,
  parameter int SCAN_DIV  = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load,
  output logic                 busy,
  output logic [7:0]           an,
  output logic [7:0]           seg
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [31:0] disp;

  function automatic logic [7:0] encode(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

`ifdef DECIMAL_MODE_EN
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t               state, state_next;
  logic [DATA_BITS-1:0] shift_q;
  logic [31:0]          bcd_q;
  logic [31:0]          bcd_adj;
  logic [31:0]          bcd_shifted;
  logic [CNT_W-1:0]     cnt_q;
  logic                 last_step;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end
  end

  // Bits shifted out of the top nibble are dropped, leaving the value mod 10^8.
  assign bcd_shifted = {bcd_adj[30:0], shift_q[DATA_BITS-1]};
  assign last_step   = (state == CONV) && (cnt_q == CNT_W'(1));
  assign busy        = (state == CONV);

  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONV;
      CONV:    if (cnt_q == CNT_W'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && load) begin
        shift_q <= data_in;
        bcd_q   <= '0;
        cnt_q   <= CNT_W'(DATA_BITS);
      end else if (state == CONV) begin
        shift_q <= shift_q << 1;
        bcd_q   <= bcd_shifted;
        cnt_q   <= cnt_q - CNT_W'(1);
      end
      if (last_step) disp <= bcd_shifted;
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp <= '0;
    end else if (load) begin
      disp <= 32'(data_in);
    end
  end
`endif

  logic [DIV_W-1:0] div_q;
  logic [2:0]       idx_q;

  // The scan free-runs; it never looks at load or busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
      an    <= 8'hFF;
      seg   <= 8'hFF;
    end else begin
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
        div_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      an  <= ~(8'b1 << idx_q);
      seg <= encode(disp[idx_q*4 +: 4]);
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Randomized self-checking bench for seg_display_driver; the display is observed only through an/seg.
// Build with DECIMAL_MODE_EN defined to exercise the BCD engine, otherwise the hex path is checked.
module tb_seg_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        load;
  logic        busy;
  logic [7:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  logic [7:0] glyph_tbl [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_display_driver #(.DATA_BITS(32), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load),
    .busy(busy), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what the eight digits should hold after a load of v.
  function automatic logic [31:0] model_disp(input logic [31:0] v);
    logic [31:0] res;
`ifdef DECIMAL_MODE_EN
    longint unsigned r;
    r = longint'(v) % 64'd100000000;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      res[k*4 +: 4] = 4'(r % 10);
      r = r / 10;
    end
`else
    res = v;
`endif
    return res;
  endfunction

  task automatic do_load(input logic [31:0] v);
    int n;
    data_in = v;
    load    = 1'b1;
    tick();
    load    = 1'b0;
`ifdef DECIMAL_MODE_EN
    check("busy_rise", {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("busy_len", n, 32'd32);
`else
    check("busy_hex", {31'd0, busy}, 32'd0);
`endif
  endtask

  // Watch a full scan period and compare the glyph shown on every digit.
  task automatic scan_check(input string tag, input logic [31:0] exp);
    logic [7:0] seen [8];
    int bad;
    int idx;
    bad = 0;
    for (int k = 0; k < 8; k++) seen[k] = 8'h00;
    repeat (2) tick();
    for (int c = 0; c < 36; c++) begin
      tick();
      idx = -1;
      for (int k = 0; k < 8; k++) if (an == ~(8'b1 << k)) idx = k;
      if (idx < 0) bad++;
      else seen[idx] = seg;
`ifndef DECIMAL_MODE_EN
      if (busy) bad++;
`endif
    end
    check({tag, "_scan"}, bad, 32'd0);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_d%0d", tag, k), {24'd0, seen[k]}, {24'd0, glyph_tbl[exp[k*4 +: 4]]});
  endtask

  initial begin
    logic [31:0] v;
    int n;

    // Reset with load also asserted: reset must win.
    rst = 1'b1; load = 1'b1; data_in = 32'hFFFF_FFFF;
    repeat (3) begin
      tick();
      check("rst_an", {24'd0, an}, 32'hFF);
      check("rst_seg", {24'd0, seg}, 32'hFF);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b0; load = 1'b0;
    tick();
    check("post_rst_an", {24'd0, an}, 32'hFE);
    check("post_rst_seg", {24'd0, seg}, 32'hC0);
    repeat (4) tick();
    check("scan_d1_an", {24'd0, an}, 32'hFD);
    repeat (28) tick();
    check("scan_wrap_an", {24'd0, an}, 32'hFE);

    do_load(32'h1234_ABCD);
    scan_check("hexpat", model_disp(32'h1234_ABCD));
    do_load(32'd12345678);
    scan_check("dec12345678", model_disp(32'd12345678));
    do_load(32'hFFFF_FFFF);
    scan_check("ovf", model_disp(32'hFFFF_FFFF));

    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      do_load(v);
      scan_check($sformatf("rnd%0d", i), model_disp(v));
    end

`ifdef DECIMAL_MODE_EN
    // Hold a competing load of 7 for the whole conversion of 5, including the falling cycle.
    data_in = 32'd5; load = 1'b1;
    tick();
    data_in = 32'd7;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    load = 1'b0;
    check("busy_len_hold", n, 32'd32);
    tick();
    check("no_queue", {31'd0, busy}, 32'd0);
    scan_check("first_wins", model_disp(32'd5));
    // Back-to-back: the second load lands the cycle after busy falls.
    do_load($urandom);
    do_load(32'd7);
    scan_check("back2back", model_disp(32'd7));
`endif

    // Reset in the middle of a conversion discards it.
    data_in = 32'd99; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    scan_check("midrst", 32'd0);
    do_load(32'd3);
    scan_check("after_rst", model_disp(32'd3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
